// File: rtl/order_tx_arbiter.sv
// Shares the serial order link between the user interface and the CPU:
// one-entry request slots, round-robin grant, MSB-first serializer with gap.
module order_tx_arbiter #(
  parameter int unsigned DATA_W  = 32,
  parameter int unsigned BIT_DIV = 4,
  parameter int unsigned GAP     = 8
) (
  input  logic              clk,
  input  logic              CPU_RESETN,
  input  logic              usr_req,
  input  logic [DATA_W-1:0] usr_order,
  output logic              usr_full,
  input  logic              cpu_req,
  input  logic [DATA_W-1:0] cpu_order,
  output logic              cpu_full,
  output logic              tx_busy,
  output logic              dataPingOut,
  output logic              comEnOut,
  output logic              sent_pulse,
  output logic              sent_src,
  output logic [7:0]        drop_cnt
);

  localparam int unsigned DIV_W = (BIT_DIV > 1) ? $clog2(BIT_DIV) : 1;
  localparam int unsigned BIT_W = (DATA_W > 1) ? $clog2(DATA_W) : 1;
  localparam int unsigned GAP_W = (GAP > 1) ? $clog2(GAP) : 1;
  localparam int unsigned CNT_W = 8;
  localparam int unsigned SUM_W = CNT_W + 1;

  typedef enum logic [1:0] {ST_IDLE, ST_LOAD, ST_SHIFT, ST_GAP} state_t;

  state_t              state_q, state_d;
  logic                usr_full_q, usr_full_d;
  logic                cpu_full_q, cpu_full_d;
  logic [DATA_W-1:0]   usr_slot_q, usr_slot_d;
  logic [DATA_W-1:0]   cpu_slot_q, cpu_slot_d;
  logic [DATA_W-1:0]   shift_q, shift_d;
  logic                last_cpu_q, last_cpu_d;
  logic                src_q, src_d;
  logic                sent_src_q, sent_src_d;
  logic                sent_pulse_q, sent_pulse_d;
  logic                com_en_q, com_en_d;
  logic                data_q, data_d;
  logic                busy_q, busy_d;
  logic [CNT_W-1:0]    drop_cnt_q, drop_cnt_d;
  logic [DIV_W-1:0]    div_cnt_q, div_cnt_d;
  logic [BIT_W-1:0]    bit_cnt_q, bit_cnt_d;
  logic [GAP_W-1:0]    gap_cnt_q, gap_cnt_d;

  logic                grant_usr, grant_cpu;
  logic                usr_drop, cpu_drop;
  logic [1:0]          drop_inc;
  logic [SUM_W-1:0]    drop_sum;

  // Arbitration, slot capture, serializer FSM and drop accounting
  always_comb begin
    state_d      = state_q;
    usr_full_d   = usr_full_q;
    cpu_full_d   = cpu_full_q;
    usr_slot_d   = usr_slot_q;
    cpu_slot_d   = cpu_slot_q;
    shift_d      = shift_q;
    last_cpu_d   = last_cpu_q;
    src_d        = src_q;
    sent_src_d   = sent_src_q;
    sent_pulse_d = 1'b0;
    com_en_d     = com_en_q;
    data_d       = data_q;
    div_cnt_d    = div_cnt_q;
    bit_cnt_d    = bit_cnt_q;
    gap_cnt_d    = gap_cnt_q;

    // On a tie the requester that was not granted last wins
    grant_usr = (state_q == ST_IDLE) && usr_full_q && (!cpu_full_q || last_cpu_q);
    grant_cpu = (state_q == ST_IDLE) && cpu_full_q && !grant_usr;

    unique case (state_q)
      ST_IDLE: begin
        if (grant_usr || grant_cpu) begin
          state_d    = ST_LOAD;
          shift_d    = grant_usr ? usr_slot_q : cpu_slot_q;
          last_cpu_d = grant_cpu;
          src_d      = grant_cpu;
          div_cnt_d  = '0;
          bit_cnt_d  = '0;
        end
      end
      ST_LOAD: begin
        state_d  = ST_SHIFT;
        com_en_d = 1'b1;
        data_d   = shift_q[DATA_W-1];
        shift_d  = {shift_q[DATA_W-2:0], 1'b0};
      end
      ST_SHIFT: begin
        if (div_cnt_q == DIV_W'(BIT_DIV - 1)) begin
          div_cnt_d = '0;
          if (bit_cnt_q == BIT_W'(DATA_W - 1)) begin
            state_d      = ST_GAP;
            com_en_d     = 1'b0;
            data_d       = 1'b0;
            sent_pulse_d = 1'b1;
            sent_src_d   = src_q;
            gap_cnt_d    = '0;
          end else begin
            bit_cnt_d = bit_cnt_q + BIT_W'(1);
            data_d    = shift_q[DATA_W-1];
            shift_d   = {shift_q[DATA_W-2:0], 1'b0};
          end
        end else begin
          div_cnt_d = div_cnt_q + DIV_W'(1);
        end
      end
      ST_GAP: begin
        if (gap_cnt_q == GAP_W'(GAP - 1)) begin
          state_d = ST_IDLE;
        end else begin
          gap_cnt_d = gap_cnt_q + GAP_W'(1);
        end
      end
      default: state_d = ST_IDLE;
    endcase

    // A write landing on the grant edge refills the slot being emptied
    if (grant_usr) usr_full_d = 1'b0;
    if (grant_cpu) cpu_full_d = 1'b0;
    usr_drop = usr_req && usr_full_q && !grant_usr;
    cpu_drop = cpu_req && cpu_full_q && !grant_cpu;
    if (usr_req && !usr_drop) begin
      usr_full_d = 1'b1;
      usr_slot_d = usr_order;
    end
    if (cpu_req && !cpu_drop) begin
      cpu_full_d = 1'b1;
      cpu_slot_d = cpu_order;
    end

    drop_inc = 2'(usr_drop) + 2'(cpu_drop);
    drop_sum = {1'b0, drop_cnt_q} + SUM_W'(drop_inc);
    if (drop_sum > SUM_W'(255)) begin
      drop_cnt_d = 8'hFF;
    end else begin
      drop_cnt_d = drop_sum[CNT_W-1:0];
    end

    busy_d = (state_d != ST_IDLE);
  end

  always_ff @(posedge clk) begin
    if (!CPU_RESETN) begin
      state_q      <= ST_IDLE;
      usr_full_q   <= 1'b0;
      cpu_full_q   <= 1'b0;
      usr_slot_q   <= '0;
      cpu_slot_q   <= '0;
      shift_q      <= '0;
      last_cpu_q   <= 1'b1;
      src_q        <= 1'b0;
      sent_src_q   <= 1'b0;
      sent_pulse_q <= 1'b0;
      com_en_q     <= 1'b0;
      data_q       <= 1'b0;
      busy_q       <= 1'b0;
      drop_cnt_q   <= '0;
      div_cnt_q    <= '0;
      bit_cnt_q    <= '0;
      gap_cnt_q    <= '0;
    end else begin
      state_q      <= state_d;
      usr_full_q   <= usr_full_d;
      cpu_full_q   <= cpu_full_d;
      usr_slot_q   <= usr_slot_d;
      cpu_slot_q   <= cpu_slot_d;
      shift_q      <= shift_d;
      last_cpu_q   <= last_cpu_d;
      src_q        <= src_d;
      sent_src_q   <= sent_src_d;
      sent_pulse_q <= sent_pulse_d;
      com_en_q     <= com_en_d;
      data_q       <= data_d;
      busy_q       <= busy_d;
      drop_cnt_q   <= drop_cnt_d;
      div_cnt_q    <= div_cnt_d;
      bit_cnt_q    <= bit_cnt_d;
      gap_cnt_q    <= gap_cnt_d;
    end
  end

  assign usr_full    = usr_full_q;
  assign cpu_full    = cpu_full_q;
  assign tx_busy     = busy_q;
  assign dataPingOut = data_q;
  assign comEnOut    = com_en_q;
  assign sent_pulse  = sent_pulse_q;
  assign sent_src    = sent_src_q;
  assign drop_cnt    = drop_cnt_q;

endmodule

// File: tb/tb_order_tx_arbiter.sv
// Scoreboard bench for order_tx_arbiter: expected frames are queued when
// requests are driven and checked by a serial-link monitor as frames end.
module tb_order_tx_arbiter;

  localparam int DATA_W  = 32;
  localparam int BIT_DIV = 4;
  localparam int GAP     = 8;
  localparam int FRAME_HI = DATA_W * BIT_DIV;

  logic              clk = 1'b0;
  logic              CPU_RESETN = 1'b0;
  logic              usr_req = 1'b0;
  logic [DATA_W-1:0] usr_order = '0;
  logic              usr_full;
  logic              cpu_req = 1'b0;
  logic [DATA_W-1:0] cpu_order = '0;
  logic              cpu_full;
  logic              tx_busy;
  logic              dataPingOut;
  logic              comEnOut;
  logic              sent_pulse;
  logic              sent_src;
  logic [7:0]        drop_cnt;

  int tests_run = 0;
  int fails = 0;

  logic [DATA_W:0]   sb[$];
  logic              src_hist[$];
  int                frames_done = 0;
  int                hi_cnt = 0;
  int                lo_cnt = 0;
  int                gap_at_rise = 0;
  logic              prev_en = 1'b0;
  logic [DATA_W-1:0] rx_word = '0;

  order_tx_arbiter #(.DATA_W(DATA_W), .BIT_DIV(BIT_DIV), .GAP(GAP)) dut (
    .clk(clk), .CPU_RESETN(CPU_RESETN),
    .usr_req(usr_req), .usr_order(usr_order), .usr_full(usr_full),
    .cpu_req(cpu_req), .cpu_order(cpu_order), .cpu_full(cpu_full),
    .tx_busy(tx_busy), .dataPingOut(dataPingOut), .comEnOut(comEnOut),
    .sent_pulse(sent_pulse), .sent_src(sent_src), .drop_cnt(drop_cnt)
  );

  always #5 clk = ~clk;

  // Link monitor: decodes frames on the falling edge and checks them against the scoreboard
  always @(negedge clk) begin
    logic [DATA_W:0] exp_v;
    if (!CPU_RESETN) begin
      prev_en = 1'b0; hi_cnt = 0; lo_cnt = 0; rx_word = '0;
    end else begin
      if (sent_pulse === 1'b1 && !(prev_en && comEnOut === 1'b0)) begin
        tests_run++; fails++;
        $display("FAIL stray_sent_pulse: sent_pulse=1 with no frame ending, comEnOut=%b", comEnOut);
      end
      if (comEnOut === 1'b1) begin
        if (!prev_en) begin gap_at_rise = lo_cnt; hi_cnt = 0; end
        if ((hi_cnt % BIT_DIV) == 0) rx_word = {rx_word[DATA_W-2:0], dataPingOut};
        hi_cnt++;
      end else if (prev_en) begin
        tests_run++;
        if (hi_cnt !== FRAME_HI) begin
          fails++; $display("FAIL frame_len: comEnOut high %0d cycles, need %0d", hi_cnt, FRAME_HI);
        end
        tests_run++;
        if (sent_pulse !== 1'b1) begin
          fails++; $display("FAIL sent_pulse_at_end: got %b need 1", sent_pulse);
        end
        tests_run++;
        if (sb.size() == 0) begin
          fails++; $display("FAIL frame_unexpected: word %h src %b with empty scoreboard", rx_word, sent_src);
        end else begin
          exp_v = sb.pop_front();
          if (rx_word !== exp_v[DATA_W-1:0] || sent_src !== exp_v[DATA_W]) begin
            fails++;
            $display("FAIL frame_data: got word %h src %b, need word %h src %b",
                     rx_word, sent_src, exp_v[DATA_W-1:0], exp_v[DATA_W]);
          end
        end
        frames_done++;
        src_hist.push_back(sent_src);
        lo_cnt = 1;
      end else begin
        lo_cnt++;
      end
      prev_en = (comEnOut === 1'b1);
    end
  end

  task automatic do_reset();
    @(negedge clk);
    usr_req = 1'b0; cpu_req = 1'b0; CPU_RESETN = 1'b0;
    @(negedge clk);
    #1 CPU_RESETN = 1'b1;
  endtask

  task automatic wait_frames(input int target, input int budget, output bit ok);
    int n;
    n = 0;
    while (frames_done < target && n < budget) begin
      @(negedge clk); #1; n++;
    end
    ok = (frames_done >= target);
  endtask

  task automatic test_reset();
    do_reset();
    tests_run++;
    if ({comEnOut, dataPingOut, tx_busy, usr_full, cpu_full, sent_pulse, sent_src} !== 7'b0) begin
      fails++;
      $display("FAIL reset_flags: en=%b d=%b busy=%b uf=%b cf=%b sp=%b ss=%b, need all 0",
               comEnOut, dataPingOut, tx_busy, usr_full, cpu_full, sent_pulse, sent_src);
    end
    tests_run++;
    if (drop_cnt !== 8'd0) begin fails++; $display("FAIL reset_drop: got %0d need 0", drop_cnt); end
  endtask

  task automatic test_single();
    bit ok; int k; int base;
    do_reset();
    base = frames_done;
    sb.push_back({1'b0, 32'h11004001});
    usr_req = 1'b1; usr_order = 32'h11004001;
    @(negedge clk); usr_req = 1'b0;
    tests_run++;
    if (usr_full !== 1'b1 || comEnOut !== 1'b0) begin
      fails++; $display("FAIL single_e0: usr_full=%b comEnOut=%b, need 1 0", usr_full, comEnOut);
    end
    @(negedge clk);
    tests_run++;
    if (tx_busy !== 1'b1 || comEnOut !== 1'b0 || usr_full !== 1'b0) begin
      fails++;
      $display("FAIL single_e1: busy=%b en=%b uf=%b, need 1 0 0", tx_busy, comEnOut, usr_full);
    end
    @(negedge clk);
    tests_run++;
    if (comEnOut !== 1'b1 || dataPingOut !== 1'b0) begin
      fails++; $display("FAIL single_e2: en=%b data=%b, need 1 0", comEnOut, dataPingOut);
    end
    wait_frames(base + 1, 400, ok);
    tests_run++;
    if (!ok) begin fails++; $display("FAIL single_timeout: frames %0d need %0d", frames_done, base + 1); end
    @(negedge clk);
    tests_run++;
    if (sent_pulse !== 1'b0 || sent_src !== 1'b0) begin
      fails++; $display("FAIL single_pulse_width: sp=%b ss=%b, need 0 0", sent_pulse, sent_src);
    end
    k = 1;
    while (tx_busy === 1'b1 && k < 64) begin @(negedge clk); k++; end
    tests_run++;
    if (k !== GAP) begin fails++; $display("FAIL single_busy_tail: busy fell %0d cycles after frame, need %0d", k, GAP); end
  endtask

  task automatic test_tie();
    bit ok; int base;
    do_reset();
    base = frames_done;
    src_hist.delete();
    sb.push_back({1'b0, 32'hAAAA0001});
    sb.push_back({1'b1, 32'h55550002});
    usr_req = 1'b1; usr_order = 32'hAAAA0001;
    cpu_req = 1'b1; cpu_order = 32'h55550002;
    @(negedge clk); usr_req = 1'b0; cpu_req = 1'b0;
    wait_frames(base + 2, 800, ok);
    tests_run++;
    if (!ok) begin fails++; $display("FAIL tie_timeout: frames %0d need %0d", frames_done, base + 2); end
    tests_run++;
    if (gap_at_rise !== GAP + 2) begin
      fails++; $display("FAIL tie_gap: comEnOut low %0d cycles, need %0d", gap_at_rise, GAP + 2);
    end
    tests_run++;
    if (src_hist.size() != 2 || src_hist[0] !== 1'b0 || src_hist[1] !== 1'b1) begin
      fails++; $display("FAIL tie_order: %0d frames seen, src sequence wrong (need 0,1)", src_hist.size());
    end
  endtask

  task automatic test_overflow();
    bit ok; int base;
    do_reset();
    base = frames_done;
    sb.push_back({1'b0, 32'h1});
    sb.push_back({1'b0, 32'h2});
    for (int c = 0; c < 7; c++) begin
      usr_req = (c == 0 || c == 5 || c == 6);
      usr_order = (c == 0) ? 32'h1 : (c == 5) ? 32'h2 : 32'h3;
      @(negedge clk);
    end
    usr_req = 1'b0;
    tests_run++;
    if (drop_cnt !== 8'd1 || usr_full !== 1'b1) begin
      fails++; $display("FAIL overflow_drop: drop=%0d uf=%b, need 1 1", drop_cnt, usr_full);
    end
    wait_frames(base + 2, 800, ok);
    tests_run++;
    if (!ok) begin fails++; $display("FAIL overflow_timeout: frames %0d need %0d", frames_done, base + 2); end
  endtask

  task automatic test_fairness();
    int base; int u_loads; int c_loads; int n;
    do_reset();
    base = frames_done;
    src_hist.delete();
    for (int i = 0; i < 3; i++) begin
      sb.push_back({1'b0, 32'hA000_0000 + 32'(i)});
      sb.push_back({1'b1, 32'hC000_0000 + 32'(i)});
    end
    usr_req = 1'b1; usr_order = 32'hA000_0000;
    cpu_req = 1'b1; cpu_order = 32'hC000_0000;
    u_loads = 1; c_loads = 1; n = 0;
    while (frames_done < base + 6 && n < 2000) begin
      @(negedge clk); #1; n++;
      usr_req = 1'b0; cpu_req = 1'b0;
      if (usr_full === 1'b0 && u_loads < 3) begin
        usr_req = 1'b1; usr_order = 32'hA000_0000 + 32'(u_loads); u_loads++;
      end
      if (cpu_full === 1'b0 && c_loads < 3) begin
        cpu_req = 1'b1; cpu_order = 32'hC000_0000 + 32'(c_loads); c_loads++;
      end
    end
    usr_req = 1'b0; cpu_req = 1'b0;
    tests_run++;
    if (frames_done < base + 6) begin fails++; $display("FAIL fair_timeout: frames %0d need %0d", frames_done, base + 6); end
    for (int i = 0; i < 6; i++) begin
      tests_run++;
      if (i >= src_hist.size() || src_hist[i] !== 1'(i % 2)) begin
        fails++; $display("FAIL fair_src_%0d: src wrong or missing, need %0d", i, i % 2);
      end
    end
    tests_run++;
    if (drop_cnt !== 8'd0) begin fails++; $display("FAIL fair_drop: got %0d need 0", drop_cnt); end
  endtask

  task automatic test_drop_saturate();
    bit ok; int base; int n;
    do_reset();
    base = frames_done;
    sb.push_back({1'b0, 32'h0000_00A1});
    sb.push_back({1'b1, 32'h0000_00C1});
    sb.push_back({1'b0, 32'h0000_00B1});
    usr_req = 1'b1; usr_order = 32'h0000_00A1;
    cpu_req = 1'b1; cpu_order = 32'h0000_00C1;
    @(negedge clk);
    cpu_req = 1'b0; usr_order = 32'h0000_00B1;
    @(negedge clk);
    usr_order = 32'hDEAD_0000; cpu_order = 32'hDEAD_0001;
    usr_req = 1'b1; cpu_req = 1'b1;
    repeat (127) @(negedge clk);
    tests_run++;
    if (drop_cnt !== 8'd254) begin fails++; $display("FAIL sat_254: got %0d need 254", drop_cnt); end
    @(negedge clk);
    usr_req = 1'b0; cpu_req = 1'b0;
    tests_run++;
    if (drop_cnt !== 8'd255) begin fails++; $display("FAIL sat_255: got %0d need 255", drop_cnt); end
    wait_frames(base + 1, 400, ok);
    n = 0;
    while (comEnOut !== 1'b1 && n < 64) begin @(negedge clk); n++; end
    tests_run++;
    if (!ok || comEnOut !== 1'b1) begin fails++; $display("FAIL sat_second_frame: en=%b ok=%b, need 1 1", comEnOut, ok); end
    usr_req = 1'b1;
    repeat (44) @(negedge clk);
    usr_req = 1'b0;
    tests_run++;
    if (drop_cnt !== 8'd255 || usr_full !== 1'b1) begin
      fails++; $display("FAIL sat_hold: drop=%0d uf=%b, need 255 1", drop_cnt, usr_full);
    end
    wait_frames(base + 3, 800, ok);
    tests_run++;
    if (!ok) begin fails++; $display("FAIL sat_timeout: frames %0d need %0d", frames_done, base + 3); end
  endtask

  task automatic test_reset_midframe();
    int base; int n; int hits;
    do_reset();
    base = frames_done;
    usr_req = 1'b1; usr_order = 32'h0F0F_1234;
    @(negedge clk);
    usr_req = 1'b0; cpu_req = 1'b1; cpu_order = 32'h1357_9BDF;
    @(negedge clk);
    cpu_req = 1'b0;
    n = 0;
    while (comEnOut !== 1'b1 && n < 16) begin @(negedge clk); n++; end
    repeat (41) @(negedge clk);
    tests_run++;
    if (comEnOut !== 1'b1 || cpu_full !== 1'b1) begin
      fails++; $display("FAIL midreset_pre: en=%b cf=%b, need 1 1", comEnOut, cpu_full);
    end
    CPU_RESETN = 1'b0;
    @(negedge clk);
    tests_run++;
    if ({comEnOut, dataPingOut, tx_busy, cpu_full, sent_pulse} !== 5'b0 || drop_cnt !== 8'd0) begin
      fails++;
      $display("FAIL midreset_post: en=%b d=%b busy=%b cf=%b sp=%b drop=%0d, need all 0",
               comEnOut, dataPingOut, tx_busy, cpu_full, sent_pulse, drop_cnt);
    end
    #1 CPU_RESETN = 1'b1;
    hits = 0;
    repeat (200) begin
      @(negedge clk);
      if (sent_pulse === 1'b1 || comEnOut === 1'b1) hits++;
    end
    tests_run++;
    if (hits !== 0 || frames_done !== base) begin
      fails++; $display("FAIL midreset_quiet: %0d active cycles, frames %0d need %0d", hits, frames_done, base);
    end
  endtask

  task automatic test_same_edge();
    bit ok; int base;
    do_reset();
    base = frames_done;
    sb.push_back({1'b0, 32'h0000_1234});
    sb.push_back({1'b0, 32'h0000_BEEF});
    usr_req = 1'b1; usr_order = 32'h0000_1234;
    @(negedge clk);
    usr_order = 32'h0000_BEEF;
    @(negedge clk);
    usr_req = 1'b0;
    tests_run++;
    if (usr_full !== 1'b1 || tx_busy !== 1'b1 || drop_cnt !== 8'd0) begin
      fails++; $display("FAIL same_edge: uf=%b busy=%b drop=%0d, need 1 1 0", usr_full, tx_busy, drop_cnt);
    end
    wait_frames(base + 2, 800, ok);
    tests_run++;
    if (!ok || drop_cnt !== 8'd0) begin
      fails++; $display("FAIL same_edge_frames: frames %0d need %0d, drop=%0d", frames_done, base + 2, drop_cnt);
    end
  endtask

  initial begin
    repeat (2) @(negedge clk);
    test_reset();
    test_single();
    test_tie();
    test_overflow();
    test_fairness();
    test_drop_saturate();
    test_reset_midframe();
    test_same_edge();
    repeat (4) @(negedge clk);
    tests_run++;
    if (sb.size() != 0) begin fails++; $display("FAIL scoreboard_left: %0d frames never sent", sb.size()); end
    $display("[TB] %0d tests run, %0d failed", tests_run, fails);
    $finish;
  end

endmodule
